// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: 3-digit 7-segment scan controller with guard phases and frame-aligned value updates.
// Optional macro LEADING_ZERO_BLANK_EN keeps leading-zero digits dark during their ON phase.
module display_scan_ctrl #(
    parameter int REFRESH_DIV = 27000,
    parameter int GUARD_CYC   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] cdu_in,
    input  logic        cdu_valid,
    output logic        cdu_ready,
    output logic [11:0] cdu_out,
    output logic [2:0]  sel,
    output logic [2:0]  an_n,
    output logic        frame_done
);
    localparam int MAX_PH = (REFRESH_DIV > GUARD_CYC) ? REFRESH_DIV : GUARD_CYC;
    localparam int CW = $clog2((MAX_PH > 2) ? MAX_PH : 2);
    localparam logic [CW-1:0] ON_LAST = CW'(REFRESH_DIV - 1);
    // With no guard phase, only the post-reset GUARD visit lasts a single cycle
    localparam logic [CW-1:0] GUARD_LAST = CW'((GUARD_CYC > 0) ? GUARD_CYC - 1 : 0);

    typedef enum logic {GUARD, ON} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    sel_q, sel_d;
    logic [11:0]   cdu_out_q, cdu_out_d;
    logic [11:0]   shadow_q, shadow_d;
    logic          pending_q, pending_d;
    logic          frame_done_q, frame_done_d;
    logic          last_guard, last_on, boundary, accept;
    logic [2:0]    blank;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= GUARD;
            cnt_q        <= '0;
            sel_q        <= 3'b001;
            cdu_out_q    <= '0;
            shadow_q     <= '0;
            pending_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sel_q        <= sel_d;
            cdu_out_q    <= cdu_out_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_comb begin
        last_guard   = (state_q == GUARD) && (cnt_q == GUARD_LAST);
        last_on      = (state_q == ON) && (cnt_q == ON_LAST);
        boundary     = last_on && sel_q[2];
        accept       = cdu_valid && !pending_q;
        state_d      = (last_guard || (last_on && GUARD_CYC == 0)) ? ON : (last_on ? GUARD : state_q);
        cnt_d        = (last_guard || last_on) ? '0 : cnt_q + CW'(1);
        sel_d        = last_on ? {sel_q[1:0], sel_q[2]} : sel_q;
        frame_done_d = boundary;
        // A pending load at the boundary takes priority; ready is low then anyway
        cdu_out_d    = (boundary && pending_q) ? shadow_q : cdu_out_q;
        pending_d    = (boundary && pending_q) ? 1'b0 : (accept ? 1'b1 : pending_q);
        shadow_d     = accept ? cdu_in : shadow_q;
    end

    always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
        blank = {cdu_out_q[11:8] == 4'd0, cdu_out_q[11:4] == 8'd0, 1'b0};
`else
        blank = 3'b000;
`endif
        an_n = (state_q == ON) ? (~sel_q | blank) : 3'b111;
    end

    assign cdu_ready  = ~pending_q;
    assign cdu_out    = cdu_out_q;
    assign sel        = sel_q;
    assign frame_done = frame_done_q;
endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl: randomized self-checking bench against a cycle-index based model of the scan controller.
module tb_display_scan_ctrl;
    localparam int R = 4;
    localparam int G = 2;
    localparam int SLOT = R + G;
    localparam int FRAME = 3 * SLOT;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] cdu_in = '0;
    logic        cdu_valid = 1'b0;
    logic        cdu_ready, frame_done;
    logic [11:0] cdu_out;
    logic [2:0]  sel, an_n;
    logic [19:0] obs;

    int          checks = 0;
    int          fails = 0;
    int          t = 0;
    logic [11:0] m_disp = '0;
    logic [11:0] m_shadow = '0;
    logic        m_pend = 1'b0;

    display_scan_ctrl #(.REFRESH_DIV(R), .GUARD_CYC(G)) dut (
        .clk(clk), .rst_n(rst_n), .cdu_in(cdu_in), .cdu_valid(cdu_valid),
        .cdu_ready(cdu_ready), .cdu_out(cdu_out), .sel(sel), .an_n(an_n), .frame_done(frame_done)
    );

    always #5 clk = ~clk;
    assign obs = {sel, an_n, cdu_out, cdu_ready, frame_done};

    // Expected outputs from cycle index t (cycles since reset) and the value model
    function automatic logic [19:0] exp_vec();
        int d = (t / SLOT) % 3;
        logic [2:0] s = 3'b001 << d;
        logic [2:0] b = 3'b000;
        logic [2:0] a;
`ifdef LEADING_ZERO_BLANK_EN
        b = {m_disp[11:8] == 4'd0, m_disp[11:4] == 8'd0, 1'b0};
`endif
        a = ((t % SLOT) < G) ? 3'b111 : (~s | b);
        return {s, a, m_disp, !m_pend, (t > 0) && (t % FRAME == 0)};
    endfunction

    task automatic tick();
        @(posedge clk);
        if (!rst_n) begin
            t = 0; m_disp = '0; m_shadow = '0; m_pend = 1'b0;
        end else begin
            if ((t % FRAME == FRAME - 1) && m_pend) begin
                m_disp = m_shadow; m_pend = 1'b0;
            end else if (cdu_valid && !m_pend) begin
                m_shadow = cdu_in; m_pend = 1'b1;
            end
            t++;
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; cdu_valid = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cdu_valid = 1'b1; cdu_in = 12'hfff;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (obs !== {3'b001, 3'b111, 12'h000, 1'b1, 1'b0}) begin
                fails++; $display("FAIL reset cyc%0d got %h exp %h", i, obs, {3'b001, 3'b111, 12'h000, 1'b1, 1'b0});
            end
        end
        cdu_valid = 1'b0; rst_n = 1'b1;
    endtask

    task automatic test_scan_timing();
        int first_fd = -1;
        do_reset();
        for (int i = 0; i < 2 * FRAME + 3; i++) begin
            checks++;
            if (obs !== exp_vec()) begin
                fails++; $display("FAIL scan t=%0d got %h exp %h", t, obs, exp_vec());
            end
            if (frame_done && first_fd < 0) first_fd = t;
            tick();
        end
        checks++;
        if (first_fd !== 18) begin
            fails++; $display("FAIL first_frame_done got %0d exp 18", first_fd);
        end
    endtask

    task automatic test_update();
        do_reset();
        while (t < 5) tick();
        cdu_in = 12'h123; cdu_valid = 1'b1;
        tick();
        cdu_valid = 1'b0; cdu_in = 12'h999;
        while (t < 40) begin
            checks++;
            if (obs !== exp_vec()) begin
                fails++; $display("FAIL update t=%0d got %h exp %h", t, obs, exp_vec());
            end
            if (t == 6 || t == 17 || t == 18) begin
                checks++;
                if ({cdu_ready, cdu_out} !== ((t == 18) ? {1'b1, 12'h123} : {1'b0, 12'h000})) begin
                    fails++; $display("FAIL update_pt t=%0d got %h", t, {cdu_ready, cdu_out});
                end
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        while (t < 5) tick();
        cdu_in = 12'h123; cdu_valid = 1'b1;
        tick();
        cdu_in = 12'h456;
        while (t < 60) begin
            checks++;
            if (obs !== exp_vec()) begin
                fails++; $display("FAIL b2b t=%0d got %h exp %h", t, obs, exp_vec());
            end
            if (t == 18 || t == 19 || t == 36) begin
                checks++;
                if ({cdu_ready, cdu_out} !== ((t == 18) ? {1'b1, 12'h123} : (t == 19) ? {1'b0, 12'h123} : {1'b1, 12'h456})) begin
                    fails++; $display("FAIL b2b_pt t=%0d got %h", t, {cdu_ready, cdu_out});
                end
            end
            if (m_pend && m_shadow == 12'h456) cdu_valid = 1'b0;
            tick();
        end
    endtask

    task automatic test_blanking();
        logic [11:0] vals [2] = '{12'h007, 12'h040};
        logic [2:0] lit;
        logic [2:0] want;
        foreach (vals[k]) begin
            do_reset();
            cdu_in = vals[k]; cdu_valid = 1'b1;
            tick();
            cdu_valid = 1'b0;
            for (int i = 0; i < 3 * FRAME && m_disp != vals[k]; i++) tick();
            lit = 3'b000;
            for (int i = 0; i < FRAME; i++) begin
                checks++;
                if (obs !== exp_vec()) begin
                    fails++; $display("FAIL blank t=%0d got %h exp %h", t, obs, exp_vec());
                end
                lit |= ~an_n;
                tick();
            end
`ifdef LEADING_ZERO_BLANK_EN
            want = (k == 0) ? 3'b001 : 3'b011;
`else
            want = 3'b111;
`endif
            checks++;
            if (lit !== want) begin
                fails++; $display("FAIL blank_lit val=%h got %b exp %b", vals[k], lit, want);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        while (t < 6) tick();
        cdu_in = 12'habc; cdu_valid = 1'b1;
        tick();
        cdu_valid = 1'b0;
        while (t < 9) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if (obs !== {3'b001, 3'b111, 12'h000, 1'b1, 1'b0}) begin
            fails++; $display("FAIL reset_mid got %h exp %h", obs, {3'b001, 3'b111, 12'h000, 1'b1, 1'b0});
        end
        while (t < 2 * FRAME) begin
            checks++;
            if (obs !== exp_vec()) begin
                fails++; $display("FAIL reset_mid_run t=%0d got %h exp %h", t, obs, exp_vec());
            end
            tick();
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            cdu_valid = ($urandom_range(0, 99) < 30);
            cdu_in = 12'($urandom);
            rst_n = ($urandom_range(0, 199) != 0);
            tick();
            rst_n = 1'b1;
            checks++;
            if (obs !== exp_vec()) begin
                fails++; $display("FAIL random i=%0d t=%0d got %h exp %h", i, t, obs, exp_vec());
            end
        end
        cdu_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_scan_timing();
        test_update();
        test_back_to_back();
        test_blanking();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
